// File: rtl/spi_ctl_mc.sv
// SPI mode-0 slave that decodes framed commands onto NUM_CH UART channel interfaces.
// Optional: define SPI_CTL_MC_BURST_EN so one CMD byte covers every following word in a cs_n window.
module spi_ctl_mc #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BAUD_W   = 16,
  parameter int unsigned BAUD_RST = 434
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sck,
  input  logic                       cs_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic [NUM_CH*DATA_W-1:0]   tx_fifo_data,
  input  logic [NUM_CH-1:0]          tx_fifo_full,
  output logic [NUM_CH-1:0]          tx_fifo_en,
  input  logic [NUM_CH*DATA_W-1:0]   rx_fifo_data,
  input  logic [NUM_CH-1:0]          rx_fifo_empty,
  output logic [NUM_CH-1:0]          rx_fifo_en,
  input  logic [NUM_CH*4-1:0]        state,
  output logic [NUM_CH*2-1:0]        control,
  output logic [NUM_CH*BAUD_W-1:0]   baud
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  localparam logic [2:0] OpTx     = 3'b000;
  localparam logic [2:0] OpRx     = 3'b001;
  localparam logic [2:0] OpBaudWr = 3'b010;
  localparam logic [2:0] OpCtrlWr = 3'b011;
  localparam logic [2:0] OpStat   = 3'b100;
  localparam logic [2:0] OpBaudRd = 3'b101;

  typedef enum logic [2:0] {StIdle, StCmd, StFetch, StData, StCommit} st_e;

  function automatic logic is_read(input logic [2:0] op_in);
    return (op_in == OpRx) || (op_in == OpStat) || (op_in == OpBaudRd);
  endfunction

  logic [1:0]                sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                      sck_prev_q;
  st_e                       st_q, st_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      fetch_cnt_q, fetch_cnt_d;
  logic [7:0]                cmd_q, cmd_d;
  logic [DATA_W-1:0]         din_q, din_d;
  logic [DATA_W-1:0]         dout_q, dout_d;
  logic                      pop_q, pop_d;
  logic                      miso_q, miso_d;
  logic [NUM_CH-1:0]         tx_en_q, tx_en_d;
  logic [NUM_CH-1:0]         rx_en_q, rx_en_d;
  logic [NUM_CH-1:0]         ovf_q, ovf_d;
  logic [NUM_CH-1:0]         udf_q, udf_d;
  logic [NUM_CH*DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [NUM_CH*2-1:0]       ctrl_q, ctrl_d;
  logic [NUM_CH*BAUD_W-1:0]  baud_q, baud_d;
`ifdef SPI_CTL_MC_BURST_EN
  logic [DATA_W-1:0]         rd_word_q, rd_word_d;
`endif

  logic                      sck_s, cs_s, mosi_s, sck_rise, sck_fall;
  logic [7:0]                cmd_in, fcmd;
  logic [2:0]                op;
  logic [NUM_CH-1:0]         ch_oh, fch_oh;
  logic                      sel_full, f_empty;
  logic [DATA_W-1:0]         sel_rx_data, rd_word;
  logic [7:0]                sel_status;
  logic [BAUD_W-1:0]         sel_baud;
  logic                      fetch_go;
  logic [NUM_CH-1:0]         ovf_set, udf_set, flag_clr;

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // The command byte completes on the same cycle it is decoded, so look ahead at the incoming bit.
  assign cmd_in = {cmd_q[6:0], mosi_s};
  assign fcmd   = (st_q == StCmd) ? cmd_in : cmd_q;
  assign op     = cmd_q[7:5];

  // Channel decode; an out-of-range channel matches nothing and selects zeros.
  always_comb begin
    ch_oh       = '0;
    fch_oh      = '0;
    sel_full    = 1'b0;
    f_empty     = 1'b0;
    sel_rx_data = '0;
    sel_status  = '0;
    sel_baud    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_oh[c]  = (cmd_q[4:0] == 5'(c));
      fch_oh[c] = (fcmd[4:0] == 5'(c));
      if (ch_oh[c]) begin
        sel_full    = tx_fifo_full[c];
        sel_rx_data = rx_fifo_data[c*DATA_W +: DATA_W];
        sel_status  = {udf_q[c], ovf_q[c], tx_fifo_full[c], rx_fifo_empty[c], state[c*4 +: 4]};
        sel_baud    = baud_q[c*BAUD_W +: BAUD_W];
      end
      if (fch_oh[c]) f_empty = rx_fifo_empty[c];
    end
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    cmd_d       = cmd_q;
    din_d       = din_q;
    dout_d      = dout_q;
    pop_d       = pop_q;
    miso_d      = miso_q;
    tx_en_d     = '0;
    rx_en_d     = '0;
    tx_data_d   = tx_data_q;
    ctrl_d      = ctrl_q;
    baud_d      = baud_q;
    rd_word     = '0;
    fetch_go    = 1'b0;
    ovf_set     = '0;
    udf_set     = '0;
    flag_clr    = '0;
`ifdef SPI_CTL_MC_BURST_EN
    rd_word_d   = rd_word_q;
`endif

    unique case (st_q)
      StIdle: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (!cs_s) st_d = StCmd;
      end
      StCmd: begin
        if (sck_fall) miso_d = 1'b0;
        if (sck_rise) begin
          cmd_d = cmd_in;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(7)) begin
            cnt_d  = '0;
            dout_d = '0;
            if (is_read(cmd_in[7:5])) begin
              st_d        = StFetch;
              fetch_go    = 1'b1;
              fetch_cnt_d = 1'b0;
            end else begin
              st_d = StData;
            end
          end
        end
      end
      StFetch: begin
        // Cycle 0 carries the pop strobe; cycle 1 sees the popped data and loads the shifter.
        fetch_cnt_d = 1'b1;
        if (fetch_cnt_q) begin
          unique case (op)
            OpRx:     rd_word = pop_q ? sel_rx_data : '0;
            OpStat: begin
              rd_word  = DATA_W'(sel_status);
              flag_clr = ch_oh;
            end
            OpBaudRd: rd_word = DATA_W'(sel_baud);
            default:  rd_word = '0;
          endcase
          dout_d = rd_word;
          cnt_d  = '0;
          st_d   = StData;
`ifdef SPI_CTL_MC_BURST_EN
          rd_word_d = rd_word;
`endif
        end
      end
      StData: begin
        if (sck_fall) begin
          miso_d = dout_q[DATA_W-1];
          dout_d = {dout_q[DATA_W-2:0], 1'b0};
        end
        if (sck_rise) begin
          din_d = {din_q[DATA_W-2:0], mosi_s};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_W - 1)) begin
            cnt_d = '0;
            st_d  = StCommit;
          end
        end
      end
      StCommit: begin
        tx_en_d = (op == OpTx && !sel_full) ? ch_oh : '0;
        ovf_set = (op == OpTx && sel_full) ? ch_oh : '0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_oh[c]) begin
            if (op == OpTx && !sel_full) tx_data_d[c*DATA_W +: DATA_W] = din_q;
            if (op == OpBaudWr) baud_d[c*BAUD_W +: BAUD_W] = din_q[BAUD_W-1:0];
            if (op == OpCtrlWr) ctrl_d[c*2 +: 2] = din_q[1:0];
          end
        end
        cnt_d = '0;
        if (cs_s) begin
          st_d = StIdle;
        end else begin
`ifdef SPI_CTL_MC_BURST_EN
          if (op == OpRx) begin
            st_d        = StFetch;
            fetch_go    = 1'b1;
            fetch_cnt_d = 1'b0;
          end else begin
            st_d   = StData;
            dout_d = is_read(op) ? rd_word_q : '0;
          end
`else
          st_d = StCmd;
`endif
        end
      end
      default: st_d = StIdle;
    endcase

    if (fetch_go && fcmd[7:5] == OpRx) begin
      pop_d = 1'b0;
      if (fch_oh != '0 && !f_empty) begin
        rx_en_d = fch_oh;
        pop_d   = 1'b1;
      end else begin
        udf_set = fch_oh;
      end
    end

    // A completed frame still commits; anywhere else cs_n high abandons the frame.
    if (cs_s && st_q != StCommit && st_q != StIdle) begin
      st_d     = StIdle;
      cnt_d    = '0;
      miso_d   = 1'b0;
      pop_d    = 1'b0;
      rx_en_d  = '0;
      udf_set  = '0;
      flag_clr = '0;
    end

    ovf_d = (ovf_q & ~flag_clr) | ovf_set;
    udf_d = (udf_q & ~flag_clr) | udf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      st_q        <= StIdle;
      cnt_q       <= '0;
      fetch_cnt_q <= 1'b0;
      cmd_q       <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      pop_q       <= 1'b0;
      miso_q      <= 1'b0;
      tx_en_q     <= '0;
      rx_en_q     <= '0;
      ovf_q       <= '0;
      udf_q       <= '0;
      tx_data_q   <= '0;
      ctrl_q      <= '0;
      baud_q      <= {NUM_CH{BAUD_W'(BAUD_RST)}};
`ifdef SPI_CTL_MC_BURST_EN
      rd_word_q   <= '0;
`endif
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sck_prev_q  <= sck_s;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      cmd_q       <= cmd_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      pop_q       <= pop_d;
      miso_q      <= miso_d;
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      tx_data_q   <= tx_data_d;
      ctrl_q      <= ctrl_d;
      baud_q      <= baud_d;
`ifdef SPI_CTL_MC_BURST_EN
      rd_word_q   <= rd_word_d;
`endif
    end
  end

  assign miso         = miso_q;
  assign tx_fifo_en   = tx_en_q;
  assign rx_fifo_en   = rx_en_q;
  assign tx_fifo_data = tx_data_q;
  assign control      = ctrl_q;
  assign baud         = baud_q;

endmodule

// File: tb/tb_spi_ctl_mc.sv
// Randomised bench for spi_ctl_mc: an SPI master drives frames while a register/queue model
// predicts read words, FIFO strobes and register contents.
module tb_spi_ctl_mc;
  localparam int NCH  = 4;
  localparam int HALF = 8;

  logic              clk = 1'b0;
  logic              rst, sck, cs_n, mosi, miso;
  logic [NCH*16-1:0] tx_fifo_data, rx_fifo_data, baud;
  logic [NCH-1:0]    tx_fifo_full, tx_fifo_en, rx_fifo_empty, rx_fifo_en;
  logic [NCH*4-1:0]  state;
  logic [NCH*2-1:0]  control;

  always #5 clk = ~clk;

  spi_ctl_mc #(.NUM_CH(NCH), .DATA_W(16), .BAUD_W(16), .BAUD_RST(434)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_full(tx_fifo_full), .tx_fifo_en(tx_fifo_en),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_empty(rx_fifo_empty), .rx_fifo_en(rx_fifo_en),
    .state(state), .control(control), .baud(baud)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0]    baud_m [NCH];
  logic [1:0]     ctrl_m [NCH];
  logic [NCH-1:0] ovf_m, udf_m;
  logic [20:0]    txq [$];
  int             rxq [$];
  bit             stable = 1'b0;
  int             tx_pulses = 0;
  logic [20:0]    tx_e;
  int             rx_e;
  logic [63:0]    eb, ec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      baud_m[c] = 16'd434;
      ctrl_m[c] = 2'b00;
    end
    ovf_m = '0;
    udf_m = '0;
    txq.delete();
    rxq.delete();
  endtask

  task automatic model_frame(input logic [7:0] cmd, input logic [15:0] data,
                             output logic [15:0] r);
    int ch;
    ch = int'(cmd[4:0]);
    r  = '0;
    if (ch < NCH) begin
      case (cmd[7:5])
        3'd0: if (tx_fifo_full[ch]) ovf_m[ch] = 1'b1;
              else txq.push_back({cmd[4:0], data});
        3'd1: if (rx_fifo_empty[ch]) udf_m[ch] = 1'b1;
              else begin
                rxq.push_back(ch);
                r = rx_fifo_data[ch*16 +: 16];
              end
        3'd2: baud_m[ch] = data;
        3'd3: ctrl_m[ch] = data[1:0];
        3'd4: begin
          r = {8'h00, udf_m[ch], ovf_m[ch], tx_fifo_full[ch], rx_fifo_empty[ch],
               state[ch*4 +: 4]};
          udf_m[ch] = 1'b0;
          ovf_m[ch] = 1'b0;
        end
        3'd5: r = baud_m[ch];
        default: r = '0;
      endcase
    end
  endtask

  // Compare process: strobes against expected queues, registers whenever the bus is quiet.
  always @(negedge clk) begin
    if (!rst) begin
      if ((tx_fifo_en | rx_fifo_en) != '0)
        chk("strobe_onehot", 64'($countones({tx_fifo_en, rx_fifo_en})), 64'd1);
      for (int c = 0; c < NCH; c++) begin
        if (tx_fifo_en[c]) begin
          tx_pulses++;
          tx_e = (txq.size() != 0) ? txq.pop_front() : '1;
          chk("tx_push", {43'd0, 5'(c), tx_fifo_data[c*16 +: 16]}, {43'd0, tx_e});
        end
        if (rx_fifo_en[c]) begin
          rx_e = (rxq.size() != 0) ? rxq.pop_front() : -1;
          chk("rx_pop", 64'(c), 64'(rx_e));
        end
      end
      if (stable) begin
        for (int c = 0; c < NCH; c++) begin
          eb[c*16 +: 16] = baud_m[c];
          ec[c*2 +: 2]   = ctrl_m[c];
        end
        chk("baud_reg", 64'(baud), eb);
        chk("control_reg", 64'(control), 64'(ec[NCH*2-1:0]));
        chk("miso_idle", 64'(miso), 64'd0);
      end
    end
  end

  task automatic shift_bits(input logic [63:0] bits, input int n, output logic [63:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mosi = bits[n-1-i];
      repeat (HALF) @(negedge clk);
      got = {got[62:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    stable = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("txq_drain", 64'(txq.size()), 64'd0);
    chk("rxq_drain", 64'(rxq.size()), 64'd0);
    stable = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [15:0] data,
                          output logic [15:0] rd);
    logic [15:0] exp, dummy;
    logic [63:0] got;
    model_frame(cmd, data, exp);
`ifdef SPI_CTL_MC_BURST_EN
    // The word slot after an RX read pops again as soon as the frame commits.
    if (cmd[7:5] == 3'd1) model_frame(cmd, 16'h0000, dummy);
`endif
    shift_bits({40'd0, cmd, data}, 24, got);
    chk("miso_cmd_phase", {56'd0, got[23:16]}, 64'd0);
    chk("read_word", {48'd0, got[15:0]}, {48'd0, exp});
    rd = got[15:0];
  endtask

  task automatic set_env();
    tx_fifo_full  = NCH'($urandom);
    rx_fifo_empty = NCH'($urandom);
    state         = (NCH*4)'($urandom);
    rx_fifo_data  = {$urandom, $urandom};
  endtask

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [63:0] got;
    int p, nfr, ch;
    logic [7:0] cmd;

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_fifo_full = '0; rx_fifo_empty = '1; state = 16'h4321; rx_fifo_data = '0;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_baud", 64'(baud), 64'h01B2_01B2_01B2_01B2);
    chk("rst_control", 64'(control), 64'd0);
    chk("rst_strobes", 64'({tx_fifo_en, rx_fifo_en}), 64'd0);
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_tx_data", 64'(tx_fifo_data), 64'd0);
    stable = 1'b1;

    // TX write to ch2, then with ch2 full, then status reads clearing ovf.
    p = tx_pulses;
    cs_begin(); do_frame(8'h02, 16'hA5A5, rd); cs_end();
    chk("tx_pulse_cnt", 64'(tx_pulses - p), 64'd1);
    chk("tx_data_ch2", 64'(tx_fifo_data[47:32]), 64'hA5A5);
    tx_fifo_full = 4'b0100;
    p = tx_pulses;
    cs_begin(); do_frame(8'h02, 16'h5A5A, rd); cs_end();
    chk("tx_full_no_pulse", 64'(tx_pulses - p), 64'd0);
    cs_begin(); do_frame(8'h82, 16'h0000, rd); cs_end();
    chk("status_ovf_set", 64'(rd[6]), 64'd1);
    cs_begin(); do_frame(8'h82, 16'h0000, rd); cs_end();
    chk("status_ovf_clr", 64'(rd[6]), 64'd0);

    // RX read ch1, non-empty then empty.
    rx_fifo_empty = 4'b1101;
    rx_fifo_data[31:16] = 16'h1234;
    cs_begin(); do_frame(8'h21, 16'h0000, rd); cs_end();
    chk("rx_word", 64'(rd), 64'h1234);
    rx_fifo_empty = 4'b1111;
    cs_begin(); do_frame(8'h21, 16'h0000, rd); cs_end();
    chk("rx_empty_word", 64'(rd), 64'h0000);
    cs_begin(); do_frame(8'h81, 16'h0000, rd); cs_end();
    chk("status_udf", 64'(rd[7]), 64'd1);

    // Baud and control writes, baud read-back.
    cs_begin(); do_frame(8'h43, 16'h0100, rd); cs_end();
    chk("baud_ch3", 64'(baud[63:48]), 64'h0100);
    cs_begin(); do_frame(8'hA3, 16'h0000, rd); cs_end();
    chk("baud_read_ch3", 64'(rd), 64'h0100);
    cs_begin(); do_frame(8'h63, 16'hFFFE, rd); cs_end();
    chk("control_ch3", 64'(control[7:6]), 64'd2);

    // Abort after 12 bits, then a full frame on a fresh window.
    tx_fifo_full = '0;
    p = tx_pulses;
    cs_begin(); shift_bits(64'h02F, 12, got); cs_end();
    chk("abort_no_pulse", 64'(tx_pulses - p), 64'd0);
    cs_begin(); do_frame(8'h00, 16'h1357, rd); cs_end();
    chk("after_abort_pulse", 64'(tx_pulses - p), 64'd1);

    // Out-of-range channel.
    p = tx_pulses;
    cs_begin(); do_frame(8'h1F, 16'hBEEF, rd); cs_end();
    cs_begin(); do_frame(8'h9F, 16'h0000, rd); cs_end();
    chk("ch31_status", 64'(rd), 64'd0);
    cs_begin(); do_frame(8'hBF, 16'h0000, rd); cs_end();
    chk("ch31_baud", 64'(rd), 64'd0);
    chk("ch31_no_pulse", 64'(tx_pulses - p), 64'd0);

`ifdef SPI_CTL_MC_BURST_EN
    p = tx_pulses;
    cs_begin();
    model_frame(8'h00, 16'h1111, rd);
    model_frame(8'h00, 16'h2222, rd);
    model_frame(8'h00, 16'h3333, rd);
    shift_bits({8'h00, 8'h00, 48'h1111_2222_3333}, 56, got);
    cs_end();
    chk("burst_pulses", 64'(tx_pulses - p), 64'd3);
`else
    cs_begin();
    do_frame(8'h41, 16'h0055, rd);
    do_frame(8'hA1, 16'h0000, rd);
    cs_end();
    chk("b2b_baud_read", 64'(rd), 64'h0055);
`endif

    // Reset in the middle of a frame.
    cs_begin();
    shift_bits(64'h40ABCD >> 14, 10, got);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; cs_n = 1'b1;
    model_reset();
    repeat (8) @(negedge clk);
    chk("midrst_baud", 64'(baud), 64'h01B2_01B2_01B2_01B2);
    chk("midrst_control", 64'(control), 64'd0);
    stable = 1'b1;

    // Random windows.
    for (int w = 0; w < 90; w++) begin
`ifdef SPI_CTL_MC_BURST_EN
      nfr = 1;
`else
      nfr = $urandom_range(1, 3);
`endif
      cs_begin();
      for (int f = 0; f < nfr; f++) begin
        set_env();
        ch  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 5);
        cmd = {3'($urandom_range(0, 7)), 5'(ch)};
        do_frame(cmd, 16'($urandom), rd);
      end
      cs_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
